// File: rtl/spot_finder_pkg.sv
// Shared constants, capture state encoding and the black-level helper
// for the spot finder front end.
package spot_finder_pkg;

   localparam int KERNEL_PIXELS = 32;
   localparam int PIX_W         = 8;
   localparam int WORD_W        = KERNEL_PIXELS * PIX_W;   // 256
   localparam int ADDR_W        = 14;
   localparam int SLOT_W        = $clog2(KERNEL_PIXELS);   // 5
   localparam int CNT_W         = 16;

   typedef enum logic [2:0] {
      ST_SYNC,
      ST_ARMED,
      ST_CAPTURE,
      ST_START,
      ST_WAIT_LO,
      ST_WAIT_HI
   } cap_state_t;

   // Saturating subtract of the black-level offset; never wraps below zero.
   function automatic logic [PIX_W-1:0] black_sub(input logic [PIX_W-1:0] pix,
                                                  input logic [PIX_W-1:0] lvl);
      return (pix > lvl) ? pix - lvl : '0;
   endfunction

endpackage

// File: rtl/spot_kernel_packer.sv
// Packs accepted pixels into a 32-slot kernel word. A completed kernel or a
// pad flush is presented on word/word_valid one cycle later. Slots are
// zeroed after every emitted word, so a flushed partial word carries 0x00
// in its unfilled slots without extra masking.
module spot_kernel_packer
   import spot_finder_pkg::*;
(
   input  logic              clk_in,
   input  logic              reset,
   input  logic              clear,
   input  logic              pix_accept,
   input  logic [PIX_W-1:0]  pix,
   input  logic              pad_flush,
   output logic [SLOT_W-1:0] slot,
   output logic              word_valid,
   output logic [WORD_W-1:0] word
);

   logic [KERNEL_PIXELS-1:0][PIX_W-1:0] slots, slots_nx;
   logic emit;

   assign emit = (pix_accept && slot == SLOT_W'(KERNEL_PIXELS-1)) || pad_flush;

   // Slot contents including the pixel being accepted this cycle.
   always_comb begin
      slots_nx = slots;
      if (pix_accept) slots_nx[slot] = pix;
   end

   // Slot register, slot counter and the one-cycle-latency output word.
   always_ff @(posedge clk_in) begin
      if (reset || clear) begin
         slots      <= '0;
         slot       <= '0;
         word_valid <= 1'b0;
         word       <= '0;
      end else begin
         word_valid <= emit;
         if (emit) begin
            word  <= slots_nx;
            slots <= '0;
            slot  <= '0;
         end else begin
            slots <= slots_nx;
            if (pix_accept) slot <= slot + 1'b1;
         end
      end
   end

endmodule

// File: rtl/spot_frame_capture.sv
// Camera frame capture for the spot finder: packs pixels into kernel words,
// writes them linearly to BRAM, measures frame geometry and hands a clean
// frame to the finder via finder_start / analysis_rdy.
// Optional feature: define SPOT_BLACK_LEVEL_EN to subtract BLACK_LEVEL
// (8-bit saturating) from each pixel before packing.
module spot_frame_capture
   import spot_finder_pkg::*;
#(
   parameter int MEM_DEPTH   = 16384,
   parameter int BLACK_LEVEL = 16
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic [PIX_W-1:0]  pix_in,
   input  logic              pix_valid,
   input  logic              line_valid,
   input  logic              frame_valid,
   input  logic              analysis_rdy,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_wr_address,
   output logic [WORD_W-1:0] mem_wr_data,
   output logic [CNT_W-1:0]  cam_kernels_x,
   output logic [CNT_W-1:0]  cam_lines_y,
   output logic              finder_start,
   output logic              capture_busy,
   output logic              frame_error,
   output logic [CNT_W-1:0]  frames_dropped
);

`ifdef SPOT_BLACK_LEVEL_EN
   localparam bit BL_EN = 1'b1;
`else
   localparam bit BL_EN = 1'b0;
`endif
   localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(MEM_DEPTH);

   cap_state_t state, state_nx;

   logic              fv_d, lv_d, fv_rise, fv_fall, lv_fall;
   logic [PIX_W-1:0]  pix_store;
   logic              pix_accept, pad_flush, pk_clear;
   logic [SLOT_W-1:0] slot;
   logic              word_valid;
   logic [ADDR_W:0]   addr_cnt;
   logic              ovf_now, line_err, err_now, err_frame, frame_bad, to_start;
   logic [CNT_W-1:0]  line_cnt, line_kern, kx_cur, kx_final, ly_final;

   // Black-level correction folds away to a wire when the feature is off.
   assign pix_store = BL_EN ? black_sub(pix_in, PIX_W'(BLACK_LEVEL)) : pix_in;

   assign fv_rise = frame_valid & ~fv_d;
   assign fv_fall = ~frame_valid & fv_d;
   assign lv_fall = ~line_valid & lv_d;

   assign pix_accept = (state == ST_CAPTURE) & pix_valid & line_valid;
   assign pad_flush  = (state == ST_CAPTURE) & lv_fall & (slot != '0);
   assign pk_clear   = (state == ST_ARMED) & fv_rise;

   // Overflow: the write beyond the last legal address is dropped.
   assign ovf_now   = word_valid & (addr_cnt >= ADDR_LIMIT);
   assign line_err  = (state == ST_CAPTURE) & lv_fall &
                      ((slot != '0) | ((line_cnt != '0) & (line_kern != kx_cur)));
   assign err_now   = ovf_now | line_err;
   assign frame_bad = err_frame | err_now;
   assign to_start  = (state == ST_CAPTURE) & (state_nx == ST_START);

   // Geometry as it stands once a line ending in this cycle is counted.
   assign ly_final = line_cnt + CNT_W'(lv_fall);
   assign kx_final = (lv_fall && line_cnt == '0) ? line_kern : kx_cur;

   assign mem_we         = word_valid & ~ovf_now;
   assign mem_wr_address = addr_cnt[ADDR_W-1:0];

   spot_kernel_packer u_packer (
      .clk_in     (clk_in),
      .reset      (reset),
      .clear      (pk_clear),
      .pix_accept (pix_accept),
      .pix        (pix_store),
      .pad_flush  (pad_flush),
      .slot       (slot),
      .word_valid (word_valid),
      .word       (mem_wr_data)
   );

   // State register.
   always_ff @(posedge clk_in) begin
      if (reset) state <= ST_SYNC;
      else       state <= state_nx;
   end

   // Next-state decode and state-derived outputs.
   always_comb begin
      state_nx     = state;
      finder_start = 1'b0;
      capture_busy = 1'b0;
      case (state)
         ST_SYNC:    if (!frame_valid) state_nx = ST_ARMED;
         ST_ARMED: begin
            capture_busy = 1'b1;
            if (fv_rise) state_nx = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            capture_busy = 1'b1;
            if (fv_fall) state_nx = frame_bad ? ST_SYNC : ST_START;
         end
         ST_START: begin
            capture_busy = 1'b1;
            finder_start = 1'b1;
            state_nx     = ST_WAIT_LO;
         end
         ST_WAIT_LO: if (!analysis_rdy) state_nx = ST_WAIT_HI;
         ST_WAIT_HI: if (analysis_rdy)  state_nx = ST_SYNC;
         default:    state_nx = ST_SYNC;
      endcase
   end

   // Edge detectors and the BRAM address counter.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         fv_d     <= 1'b0;
         lv_d     <= 1'b0;
         addr_cnt <= '0;
      end else begin
         fv_d <= frame_valid;
         lv_d <= line_valid;
         if (pk_clear)                 addr_cnt <= '0;
         else if (word_valid && !ovf_now) addr_cnt <= addr_cnt + 1'b1;
      end
   end

   // Per-frame geometry measurement and the frame's own error flag.
   always_ff @(posedge clk_in) begin
      if (reset || pk_clear) begin
         line_cnt  <= '0;
         line_kern <= '0;
         kx_cur    <= '0;
         err_frame <= 1'b0;
      end else begin
         if (err_now) err_frame <= 1'b1;
         if (state == ST_CAPTURE) begin
            if (pix_accept && slot == '0) line_kern <= line_kern + 1'b1;
            if (lv_fall) begin
               line_kern <= '0;
               line_cnt  <= line_cnt + 1'b1;
               if (line_cnt == '0) kx_cur <= line_kern;
            end
         end
      end
   end

   // Published geometry, sticky error and the dropped-frame counter.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         cam_kernels_x  <= '0;
         cam_lines_y    <= '0;
         frame_error    <= 1'b0;
         frames_dropped <= '0;
      end else begin
         if (to_start) begin
            cam_kernels_x <= kx_final;
            cam_lines_y   <= ly_final;
            frame_error   <= 1'b0;
         end else if (err_now) begin
            frame_error <= 1'b1;
         end
         if ((state == ST_WAIT_LO || state == ST_WAIT_HI) && fv_rise &&
             frames_dropped != '1)
            frames_dropped <= frames_dropped + 1'b1;
      end
   end

endmodule

// File: tb/tb_spot_frame_capture.sv
// Directed bench for spot_frame_capture with a reduced MEM_DEPTH so the
// overflow case fits in a short run. Frames are scaled-down versions of the
// camera geometries; each line carries one pix_valid bubble at x==5.
module tb_spot_frame_capture;

   localparam int MEM_DEPTH = 64;

   logic         clk_in = 1'b0;
   logic         reset;
   logic [7:0]   pix_in;
   logic         pix_valid, line_valid, frame_valid, analysis_rdy;
   logic         mem_we;
   logic [13:0]  mem_wr_address;
   logic [255:0] mem_wr_data;
   logic [15:0]  cam_kernels_x, cam_lines_y, frames_dropped;
   logic         finder_start, capture_busy, frame_error;

   int n_chk = 0;
   int n_fail = 0;
   int start_cnt = 0;
   logic [13:0]  wr_addr[$];
   logic [255:0] wr_data[$];
   logic [7:0]   sp_pix[4] = '{8'd10, 8'd16, 8'd17, 8'd255};

   always #5 clk_in = ~clk_in;

   spot_frame_capture #(.MEM_DEPTH(MEM_DEPTH), .BLACK_LEVEL(16)) dut (
      .clk_in         (clk_in),
      .reset          (reset),
      .pix_in         (pix_in),
      .pix_valid      (pix_valid),
      .line_valid     (line_valid),
      .frame_valid    (frame_valid),
      .analysis_rdy   (analysis_rdy),
      .mem_we         (mem_we),
      .mem_wr_address (mem_wr_address),
      .mem_wr_data    (mem_wr_data),
      .cam_kernels_x  (cam_kernels_x),
      .cam_lines_y    (cam_lines_y),
      .finder_start   (finder_start),
      .capture_busy   (capture_busy),
      .frame_error    (frame_error),
      .frames_dropped (frames_dropped)
   );

   // Record BRAM writes and start pulses away from the active edge.
   always @(negedge clk_in) begin
      if (mem_we) begin
         wr_addr.push_back(mem_wr_address);
         wr_data.push_back(mem_wr_data);
      end
      if (finder_start) start_cnt++;
   end

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected stored value of a pixel.
   function automatic logic [7:0] bl(input int v);
      logic [7:0] p;
      p = 8'(v);
`ifdef SPOT_BLACK_LEVEL_EN
      return (p > 8'd16) ? p - 8'd16 : 8'd0;
`else
      return p;
`endif
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   // One frame: first line w0 pixels, the rest w; optional reset at line rst_line.
   task automatic send_frame(input int w0, input int w, input int h, input int rst_line,
                             input bit special, output int wbase);
      wbase = wr_addr.size();
      frame_valid = 1'b1;
      tick(3);
      for (int y = 0; y < h; y++) begin
         if (y == rst_line) begin
            reset = 1'b1;
            tick(1);
            reset = 1'b0;
            wbase = wr_addr.size();
         end
         line_valid = 1'b1;
         for (int x = 0; x < ((y == 0) ? w0 : w); x++) begin
            if (x == 5) begin
               pix_valid = 1'b0;
               pix_in    = 8'hAA;
               tick(1);
            end
            pix_valid = 1'b1;
            pix_in    = (special && x < 4) ? sp_pix[x] : 8'(x);
            tick(1);
         end
         line_valid = 1'b0;
         pix_valid  = 1'b0;
         tick(4);
      end
      frame_valid = 1'b0;
      tick(6);
   endtask

   task automatic ack_finder();
      analysis_rdy = 1'b0;
      tick(3);
      analysis_rdy = 1'b1;
      tick(3);
   endtask

   // Count of written addresses that are not base-relative 0,1,2,...
   function automatic int addr_bad(input int base, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++)
         if (base + i >= wr_addr.size() || wr_addr[base+i] != 14'(i)) bad++;
      return bad;
   endfunction

   initial begin
      int wb, s0;
      logic [255:0] e;

      reset = 1'b1; pix_in = '0; pix_valid = 1'b0; line_valid = 1'b0;
      frame_valid = 1'b0; analysis_rdy = 1'b1;
      tick(3);
      chk("rst mem_we", 256'(mem_we), 256'd0);
      chk("rst addr", 256'(mem_wr_address), 256'd0);
      chk("rst geom", {cam_kernels_x, cam_lines_y}, 256'd0);
      chk("rst flags", {finder_start, capture_busy, frame_error}, 256'd0);
      chk("rst dropped", 256'(frames_dropped), 256'd0);
      reset = 1'b0;
      tick(3);
      chk("armed busy", 256'(capture_busy), 256'd1);

      // Good frame, 64x6 -> 2 kernels per line, 12 words.
      s0 = start_cnt;
      send_frame(64, 64, 6, -1, 1'b0, wb);
      chk("A writes", 256'(wr_addr.size() - wb), 256'd12);
      chk("A addr seq", 256'(addr_bad(wb, 12)), 256'd0);
      for (int n = 0; n < 32; n++) e[n*8 +: 8] = bl(n);
      chk("A word0", wr_data[wb], e);
      for (int n = 0; n < 32; n++) e[n*8 +: 8] = bl(32 + n);
      chk("A word11", wr_data[wb+11], e);
      chk("A start", 256'(start_cnt - s0), 256'd1);
      chk("A kx", 256'(cam_kernels_x), 256'd2);
      chk("A ly", 256'(cam_lines_y), 256'd6);
      chk("A err", 256'(frame_error), 256'd0);
      ack_finder();

      // 40-pixel lines: padded second kernel, error, geometry kept.
      s0 = start_cnt;
      send_frame(40, 40, 2, -1, 1'b0, wb);
      chk("B writes", 256'(wr_addr.size() - wb), 256'd4);
      chk("B addr seq", 256'(addr_bad(wb, 4)), 256'd0);
      e = '0;
      for (int n = 0; n < 8; n++) e[n*8 +: 8] = bl(32 + n);
      chk("B pad word", wr_data[wb+1], e);
      chk("B err", 256'(frame_error), 256'd1);
      chk("B start", 256'(start_cnt - s0), 256'd0);
      chk("B geom", {cam_kernels_x, cam_lines_y}, {16'd2, 16'd6});

      // Good frame, then three frames while the finder is still busy.
      s0 = start_cnt;
      send_frame(64, 64, 2, -1, 1'b0, wb);
      chk("C start", 256'(start_cnt - s0), 256'd1);
      chk("C err cleared", 256'(frame_error), 256'd0);
      chk("C geom", {cam_kernels_x, cam_lines_y}, {16'd2, 16'd2});
      analysis_rdy = 1'b0;
      tick(2);
      wb = wr_addr.size();
      s0 = start_cnt;
      for (int f = 0; f < 3; f++) begin
         int dummy;
         send_frame(32, 32, 1, -1, 1'b0, dummy);
      end
      chk("drop count", 256'(frames_dropped), 256'd3);
      chk("drop no writes", 256'(wr_addr.size() - wb), 256'd0);
      chk("drop no start", 256'(start_cnt - s0), 256'd0);
      analysis_rdy = 1'b1;
      tick(3);
      s0 = start_cnt;
      send_frame(32, 32, 2, -1, 1'b0, wb);
      chk("D writes", 256'(wr_addr.size() - wb), 256'd2);
      chk("D addr seq", 256'(addr_bad(wb, 2)), 256'd0);
      chk("D start", 256'(start_cnt - s0), 256'd1);
      chk("D geom", {cam_kernels_x, cam_lines_y}, {16'd1, 16'd2});
      ack_finder();

      // Reset mid-frame drops the rest of it; next frame starts at address 0.
      s0 = start_cnt;
      send_frame(64, 64, 10, 5, 1'b0, wb);
      chk("E no writes", 256'(wr_addr.size() - wb), 256'd0);
      chk("E no start", 256'(start_cnt - s0), 256'd0);
      chk("E reset outs", {cam_kernels_x, cam_lines_y, frames_dropped}, 256'd0);
      s0 = start_cnt;
      send_frame(32, 32, 3, -1, 1'b0, wb);
      chk("F writes", 256'(wr_addr.size() - wb), 256'd3);
      chk("F addr seq", 256'(addr_bad(wb, 3)), 256'd0);
      chk("F start", 256'(start_cnt - s0), 256'd1);
      chk("F geom", {cam_kernels_x, cam_lines_y}, {16'd1, 16'd3});
      ack_finder();

      // 80 kernels into a 64-word memory.
      s0 = start_cnt;
      send_frame(256, 256, 10, -1, 1'b0, wb);
      chk("G writes", 256'(wr_addr.size() - wb), 256'(MEM_DEPTH));
      chk("G addr seq", 256'(addr_bad(wb, MEM_DEPTH)), 256'd0);
      chk("G err", 256'(frame_error), 256'd1);
      chk("G start", 256'(start_cnt - s0), 256'd0);
      chk("G geom", {cam_kernels_x, cam_lines_y}, {16'd1, 16'd3});

      // Black-level values in the first four slots.
      s0 = start_cnt;
      send_frame(32, 32, 1, -1, 1'b1, wb);
`ifdef SPOT_BLACK_LEVEL_EN
      e[31:0] = {8'd239, 8'd1, 8'd0, 8'd0};
`else
      e[31:0] = {8'd255, 8'd17, 8'd16, 8'd10};
`endif
      for (int n = 4; n < 32; n++) e[n*8 +: 8] = bl(n);
      chk("H writes", 256'(wr_addr.size() - wb), 256'd1);
      chk("H black word", wr_data[wb], e);
      chk("H err cleared", 256'(frame_error), 256'd0);
      chk("H start", 256'(start_cnt - s0), 256'd1);
      chk("H geom", {cam_kernels_x, cam_lines_y}, {16'd1, 16'd1});
      ack_finder();

      // Kernel count changes between lines.
      s0 = start_cnt;
      send_frame(64, 32, 3, -1, 1'b0, wb);
      chk("I writes", 256'(wr_addr.size() - wb), 256'd4);
      chk("I err", 256'(frame_error), 256'd1);
      chk("I start", 256'(start_cnt - s0), 256'd0);
      chk("I geom", {cam_kernels_x, cam_lines_y}, {16'd1, 16'd1});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
